// File: rtl/tx_frame_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pkg
//  Description : Shared types and default constants for the TX frame
//                serializer (FSM state encoding, default frame geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_pkg;

  // Default frame geometry: 34-bit frame at 50 MHz / 115200 baud.
  localparam int TX_WORD_LENGTH  = 34;
  localparam int TX_CLKS_PER_BIT = 434;

  // Serializer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

endpackage : tx_pkg
`default_nettype wire

// File: rtl/tx_frame_serializer_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while run is
//                high and flags the final count of each bit period with tick.
//                clear forces the count back to zero and wins over run.
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen
  import tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int                CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]     c_TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          w_at_term;

  assign w_at_term = (cnt_q == c_TERM);
  // Tick only while running so an idle counter parked at zero never fires.
  assign tick      = run & w_at_term;

  // Next count: clear has priority, otherwise count and wrap at the term.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = w_at_term ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/tx_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tx_frame_serializer
//  Description : Captures a Word_Length-bit frame and shifts it out LSB-first
//                on an idle-high serial line, one bit per CLKS_PER_BIT clocks.
//                Reports busy for the whole frame and a one-clock done pulse
//                after the last bit period. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_serializer
  import tx_pkg::*;
#(
  parameter int Word_Length  = TX_WORD_LENGTH,
  parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sys_reset,
  input  logic                   start,
  input  logic [Word_Length-1:0] Data_Input,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int             BW         = $clog2(Word_Length);
  localparam logic [BW-1:0]  c_LAST_BIT = BW'(Word_Length - 1);

  tx_state_t              state_q, state_d;
  logic [Word_Length-1:0] shift_q, shift_d;
  logic [BW-1:0]          bit_q,   bit_d;
  logic                   tx_q,    tx_d;
  logic                   busy_q,  busy_d;
  logic                   done_q,  done_d;

  logic w_accept;
  logic w_tick;
  logic w_baud_clear;
  logic w_baud_run;

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

  // The bit-period counter restarts on every accept and is held at zero
  // whenever the serializer is not shifting.
  assign w_baud_clear = w_accept | sys_reset | (state_q == IDLE);
  assign w_baud_run   = (state_q == SHIFT);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (w_baud_clear),
    .run   (w_baud_run),
    .tick  (w_tick)
  );

  // Next-state and next-output logic. tx follows shift_q[0] one clock late,
  // so the last bit is still on the line during the cycle the FSM sits in
  // DONE; the done pulse and idle-high line therefore appear one clock after.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    tx_d     = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    w_accept = 1'b0;

    if (sys_reset) begin
      state_d = IDLE;
      shift_d = '1;
      bit_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            w_accept = 1'b1;
            shift_d  = Data_Input;
            bit_d    = '0;
            busy_d   = 1'b1;
            state_d  = SHIFT;
          end
        end

        SHIFT: begin
          busy_d = 1'b1;
          tx_d   = shift_q[0];
          if (w_tick) begin
            shift_d = {1'b1, shift_q[Word_Length-1:1]};
            if (bit_q == c_LAST_BIT) begin
              // Hold at the last index; the next accept reloads it.
              state_d = DONE;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end

        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '1;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule : tx_frame_serializer
`default_nettype wire
